dram_ctrl: RTL and testbench
============================

Name: dram_ctrl

Overview:
Host-side controller for the 32-bit DRAM array built from eight x4 devices sharing a 10-bit address (1024 words).
- Accepts single-word read/write requests over a valid/ready handshake.
- Drives the array's address, data and per-lane write enables.
- Returns read data with a one-cycle response pulse.
- Inserts periodic refresh cycles that sweep every row.

Parameters:
ADDR_W, 10, word address width (array depth 2^ADDR_W)
LANES, 8, number of x4 devices per word
NIB_W, 4, data width per device
REFRESH_PERIOD, 512, clock cycles between refresh requests (must be >= 8)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
req_valid  in  1  host request present
req_ready  out  1  controller accepts request this cycle
req_we  in  1  1 = write, 0 = read
req_addr  in  ADDR_W  word address
req_wdata  in  LANES*NIB_W  write data; lane i = bits [4i+3:4i]
req_be  in  LANES  per-nibble write enable (ignored for reads)
rsp_valid  out  1  one-cycle pulse, read data valid
rsp_rdata  out  LANES*NIB_W  read data
mem_addr  out  ADDR_W  array address
mem_wdata  out  LANES*NIB_W  array write data
mem_we  out  LANES  per-device write enable
mem_rdata  in  LANES*NIB_W  array read data, valid the cycle after address presented with mem_we=0

Behaviour:
Reset values and output timing
- Reset (rst=1 at an edge) forces state IDLE, clears refresh pending, sets timer to REFRESH_PERIOD-1 and refresh row to 0.
- All outputs read 0 after reset: req_ready, rsp_valid, rsp_rdata, mem_addr, mem_wdata, mem_we.
- Every output is driven from a register.

State machine: IDLE, WRITE, READ, READ_WAIT, REFRESH.
- req_ready = 1 only in IDLE with no refresh pending. Accept = req_valid & req_ready at an edge.
- IDLE:
  - Refresh pending -> REFRESH. Refresh wins over a simultaneous request; req_ready is already 0 that cycle.
  - Accepted write -> WRITE. Accepted read -> READ.
- WRITE, 1 cycle:
  - mem_addr = req_addr, mem_wdata = req_wdata, mem_we = req_be; all registered at accept.
  - Then -> IDLE. No response pulse for writes.
  - req_be = 0 is legal: a write cycle with mem_we = 0 (no-op).
- READ, 1 cycle: mem_addr = req_addr, mem_we = 0. Then -> READ_WAIT.
- READ_WAIT, 1 cycle: mem_rdata captured into rsp_rdata at the exiting edge; rsp_valid = 1 the following cycle only. Then -> IDLE.
- Read latency: accept at edge t0 gives rsp_valid high in the cycle after edge t2. Back-to-back reads therefore issue every 3 cycles.
- REFRESH, 1 cycle:
  - mem_addr = refresh row, mem_we = 0 (dummy read, data discarded).
  - Row increments and wraps 1023 -> 0. Pending clears. Then -> IDLE.

Refresh timer
- Down-counts every cycle. At 0 it sets pending and reloads REFRESH_PERIOD-1.
- Hitting 0 while already pending leaves pending set; it is not counted twice. This cannot occur with REFRESH_PERIOD >= 8.

Other rules
- mem_we is 0 in every state except WRITE.
- rsp_rdata holds its last value after the rsp_valid pulse.
- Reset mid-operation aborts the operation: no rsp_valid, and mem_we = 0 from the reset edge.
- A pending refresh is lost on reset.

Decomposition:
- dram_pkg:
  - ADDR_W, LANES and NIB_W defaults, WORD_W = LANES*NIB_W.
  - State enum {IDLE, WRITE, READ, READ_WAIT, REFRESH}.
- Sub-module refresh_timer:
  - Period down-counter plus refresh-row counter.
  - Outputs: pending, row. Inputs: clk, rst, ack (from REFRESH state).

Test Plan:
- Reset, then idle -> all outputs 0 during reset; req_ready=1 on the first cycle after reset deasserts.
- Write addr 0x005, data 0xDEADBEEF, be 0xFF; then read 0x005 -> mem_we=0xFF for exactly one cycle; rsp_valid pulse with rsp_rdata=0xDEADBEEF, 3 cycles after read accept.
- Write addr 0x005, data 0x12345678, be 0x0F (against the prior 0xDEADBEEF) -> mem_we=0x0F; readback 0xDEAD5678 (memory model honours lanes).
- REFRESH_PERIOD=16, no traffic for 16 cycles -> one REFRESH cycle with mem_addr=0, mem_we=0; the next refresh presents mem_addr=1; row wraps from 1023 to 0 after 1024 refreshes.
- req_valid held on the cycle refresh becomes pending -> req_ready=0 and the REFRESH cycle runs first; the request is accepted in the following IDLE cycle.
- Assert rst during READ_WAIT -> no rsp_valid; state IDLE; next read completes normally.

Source files
------------

// File: rtl/dram_pkg.sv
// Shared definitions for the host-side DRAM array controller.
// Array geometry defaults and the controller state encoding.
package dram_pkg;

    localparam int ADDR_W = 10;
    localparam int LANES  = 8;
    localparam int NIB_W  = 4;
    localparam int WORD_W = LANES * NIB_W;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        READ_WAIT,
        REFRESH
    } state_e;

endpackage

// File: rtl/dram_ctrl_refresh_timer.sv
// Refresh scheduler: period down-counter plus the row sweep counter.
// Ports: clk, rst, ack_i (refresh cycle running), pending_o,
//        pending_nxt_o (pending value after the coming edge), row_o.
module refresh_timer #(
    parameter int PERIOD = 512,
    parameter int ROW_W  = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ack_i,
    output logic             pending_o,
    output logic             pending_nxt_o,
    output logic [ROW_W-1:0] row_o
);

    localparam int TW = $clog2(PERIOD);
    localparam logic [TW-1:0] RELOAD = TW'(PERIOD - 1);

    logic [TW-1:0]    timer_q, timer_d;
    logic             pending_q, pending_d;
    logic [ROW_W-1:0] row_q, row_d;

    always_comb begin
        timer_d   = timer_q - 1'b1;
        pending_d = pending_q & ~ack_i;
        row_d     = row_q;
        // Expiry sets pending even if an ack lands the same cycle,
        // so a request is never dropped.
        if (timer_q == '0) begin
            timer_d   = RELOAD;
            pending_d = 1'b1;
        end
        // Row counter wraps naturally at 2^ROW_W.
        if (ack_i) begin
            row_d = row_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            timer_q   <= RELOAD;
            pending_q <= 1'b0;
            row_q     <= '0;
        end else begin
            timer_q   <= timer_d;
            pending_q <= pending_d;
            row_q     <= row_d;
        end
    end

    assign pending_o     = pending_q;
    assign pending_nxt_o = pending_d;
    assign row_o         = row_q;

endmodule

// File: rtl/dram_ctrl.sv
// Host-side controller for a 32-bit DRAM array of eight x4 devices.
// Ports: req_* host handshake in, rsp_* read response out,
//        mem_* array address/data/lane enables, all outputs registered.
module dram_ctrl
    import dram_pkg::*;
#(
    parameter int ADDR_W         = dram_pkg::ADDR_W,
    parameter int LANES          = dram_pkg::LANES,
    parameter int NIB_W          = dram_pkg::NIB_W,
    parameter int REFRESH_PERIOD = 512
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_we,
    input  logic [ADDR_W-1:0]      req_addr,
    input  logic [LANES*NIB_W-1:0] req_wdata,
    input  logic [LANES-1:0]       req_be,
    output logic                   rsp_valid,
    output logic [LANES*NIB_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [LANES*NIB_W-1:0] mem_wdata,
    output logic [LANES-1:0]       mem_we,
    input  logic [LANES*NIB_W-1:0] mem_rdata
);

    localparam int W = LANES * NIB_W;

    state_e            state_q, state_d;
    logic              ready_q, ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [W-1:0]      rdata_q, rdata_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [W-1:0]      wdata_q, wdata_d;
    logic [LANES-1:0]  we_q, we_d;

    logic              ref_pending;
    logic              ref_pending_nxt;
    logic [ADDR_W-1:0] ref_row;
    logic              ref_ack;
    logic              accept;

    assign ref_ack = (state_q == REFRESH);
    assign accept  = req_valid & ready_q;

    refresh_timer #(
        .PERIOD (REFRESH_PERIOD),
        .ROW_W  (ADDR_W)
    ) u_refresh (
        .clk           (clk),
        .rst           (rst),
        .ack_i         (ref_ack),
        .pending_o     (ref_pending),
        .pending_nxt_o (ref_pending_nxt),
        .row_o         (ref_row)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        we_d        = '0;
        rsp_valid_d = 1'b0;
        rdata_d     = rdata_q;
        unique case (state_q)
            IDLE: begin
                if (ref_pending) begin
                    state_d = REFRESH;
                    addr_d  = ref_row;
                end else if (accept) begin
                    addr_d = req_addr;
                    if (req_we) begin
                        state_d = WRITE;
                        wdata_d = req_wdata;
                        we_d    = req_be;
                    end else begin
                        state_d = READ;
                    end
                end
            end
            WRITE:     state_d = IDLE;
            READ:      state_d = READ_WAIT;
            READ_WAIT: begin
                state_d     = IDLE;
                rsp_valid_d = 1'b1;
                rdata_d     = mem_rdata;
            end
            REFRESH:   state_d = IDLE;
            default:   state_d = IDLE;
        endcase
        // Registered ready looks one edge ahead so it is already low
        // in the cycle a refresh becomes pending.
        ready_d = (state_d == IDLE) & ~ref_pending_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= '0;
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
        end
    end

    assign req_ready = ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rdata_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_we    = we_q;

endmodule

// File: tb/tb_dram_ctrl.sv
// Testbench for dram_ctrl with an x4-lane array model and a
// word-level reference memory.
module tb_dram_ctrl;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int NL = 8;
    localparam int P  = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [NL-1:0] req_be;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [NL-1:0] mem_we;
    logic [DW-1:0] mem_rdata;

    always #5 clk = ~clk;

    dram_ctrl #(
        .REFRESH_PERIOD (P)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata)
    );

    // Physical array: per-lane writes, read data one cycle after address.
    logic [DW-1:0] arr [1024];
    logic          clr;

    always @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 1024; i++) arr[i] <= '0;
        end else begin
            for (int l = 0; l < NL; l++)
                if (mem_we[l]) arr[mem_addr][4*l +: 4] <= mem_wdata[4*l +: 4];
        end
        mem_rdata <= arr[mem_addr];
    end

    // Reference contents, updated from the host's view of each write.
    logic [DW-1:0] refm [1024];
    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = 1'b1;
        tick();
        chk("rst_ready", {31'd0, req_ready}, 0);
        chk("rst_rspv", {31'd0, rsp_valid}, 0);
        chk("rst_rdata", rsp_rdata, 0);
        chk("rst_maddr", {22'd0, mem_addr}, 0);
        chk("rst_mwdata", mem_wdata, 0);
        chk("rst_mwe", {24'd0, mem_we}, 0);
        tick();
        rst = 1'b0;
        req_valid = 1'b0;
        cyc = 0;
    endtask

    task automatic handshake(input logic we, input logic [AW-1:0] a,
                             input logic [DW-1:0] d, input logic [NL-1:0] be);
        bit ok;
        bit r;
        ok = 0;
        req_valid = 1'b1;
        req_we = we;
        req_addr = a;
        req_wdata = d;
        req_be = be;
        for (int k = 0; k < 64; k++) begin
            r = req_ready;
            tick();
            if (r) begin
                ok = 1;
                break;
            end
        end
        req_valid = 1'b0;
        req_we = 1'($urandom);
        req_addr = AW'($urandom);
        req_wdata = $urandom;
        req_be = NL'($urandom);
        if (!ok) chk("accept_timeout", 0, 1);
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic [NL-1:0] be);
        handshake(1'b1, a, d, be);
        chk("wr_we", {24'd0, mem_we}, {24'd0, be});
        chk("wr_addr", {22'd0, mem_addr}, {22'd0, a});
        if (be != '0) chk("wr_data", mem_wdata, d);
        chk("wr_rspv", {31'd0, rsp_valid}, 0);
        for (int l = 0; l < NL; l++)
            if (be[l]) refm[a][4*l +: 4] = d[4*l +: 4];
        tick();
        chk("wr_we_off", {24'd0, mem_we}, 0);
    endtask

    task automatic do_read(input logic [AW-1:0] a);
        handshake(1'b0, a, '0, '0);
        chk("rd_addr", {22'd0, mem_addr}, {22'd0, a});
        chk("rd_we", {24'd0, mem_we}, 0);
        chk("rd_rspv0", {31'd0, rsp_valid}, 0);
        tick();
        chk("rd_rspv1", {31'd0, rsp_valid}, 0);
        tick();
        chk("rd_rspv2", {31'd0, rsp_valid}, 1);
        chk("rd_data", rsp_rdata, refm[a]);
        tick();
        chk("rd_rspv3", {31'd0, rsp_valid}, 0);
        chk("rd_hold", rsp_rdata, refm[a]);
    endtask

    initial begin
        logic [AW-1:0] a;
        logic [NL-1:0] be;
        int expr;
        for (int i = 0; i < 1024; i++) refm[i] = '0;
        rst = 1'b1;
        clr = 1'b1;
        req_valid = 1'b0;
        req_we = 1'b0;
        req_addr = '0;
        req_wdata = '0;
        req_be = '0;
        tick();
        clr = 1'b0;

        // Reset values, then ready on the first edge out of reset.
        do_reset();
        tick();
        chk("ready_after_rst", {31'd0, req_ready}, 1);
        chk("rspv_after_rst", {31'd0, rsp_valid}, 0);

        // Full-word write and readback.
        do_write(10'h005, 32'hDEADBEEF, 8'hFF);
        do_read(10'h005);
        chk("rd_deadbeef", rsp_rdata, 32'hDEADBEEF);

        // Partial-lane write merges with the old word.
        do_write(10'h005, 32'h12345678, 8'h0F);
        do_read(10'h005);
        chk("rd_dead5678", rsp_rdata, 32'hDEAD5678);

        // Random mixed traffic, including no-op writes.
        for (int n = 0; n < 60; n++) begin
            a = ($urandom_range(0, 3) == 0) ? 10'h3FF :
                AW'($urandom_range(0, 7));
            be = ($urandom_range(0, 7) == 0) ? '0 : NL'($urandom);
            if ($urandom_range(0, 1) == 1) do_write(a, $urandom, be);
            else do_read(a);
            for (int k = $urandom_range(0, 3); k > 0; k--) tick();
        end

        // Request held as refresh becomes pending: refresh first.
        do_reset();
        for (int n = 0; n < 16; n++) tick();
        chk("pend_ready", {31'd0, req_ready}, 0);
        req_valid = 1'b1;
        req_we = 1'b0;
        req_addr = 10'h005;
        tick();
        chk("ref_ready", {31'd0, req_ready}, 0);
        chk("ref_addr", {22'd0, mem_addr}, 0);
        chk("ref_we", {24'd0, mem_we}, 0);
        tick();
        chk("post_ref_ready", {31'd0, req_ready}, 1);
        tick();
        req_valid = 1'b0;
        chk("late_acc_addr", {22'd0, mem_addr}, 10'h005);
        tick();
        chk("late_rspv1", {31'd0, rsp_valid}, 0);
        tick();
        chk("late_rspv2", {31'd0, rsp_valid}, 1);
        chk("late_data", rsp_rdata, refm[5]);

        // Reset during READ_WAIT aborts the read.
        handshake(1'b0, 10'h003, '0, '0);
        tick();
        rst = 1'b1;
        tick();
        chk("abort_rspv", {31'd0, rsp_valid}, 0);
        chk("abort_we", {24'd0, mem_we}, 0);
        rst = 1'b0;
        tick();
        chk("abort_rspv2", {31'd0, rsp_valid}, 0);
        chk("abort_ready", {31'd0, req_ready}, 1);
        do_read(10'h003);

        // Idle sweep: refresh every P cycles, row wraps after 1024.
        do_reset();
        for (int n = 1; n <= P * 1025 + 1; n++) begin
            tick();
            chk("idle_we", {24'd0, mem_we}, 0);
            if (n <= 64) begin
                expr = (n >= P && (n % P) <= 1) ? 0 : 1;
                chk("idle_ready", {31'd0, req_ready}, 32'(expr));
            end
            if (n >= P + 1 && (n % P) == 1)
                chk("ref_row", {22'd0, mem_addr}, 32'(((n - P - 1) / P) % 1024));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
